// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states,
// and helpers that decide the signedness of each operand.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_MUL    = 3'b000;
    localparam md_op_t MD_MULH   = 3'b001;
    localparam md_op_t MD_MULHSU = 3'b010;
    localparam md_op_t MD_MULHU  = 3'b011;
    localparam md_op_t MD_DIV    = 3'b100;
    localparam md_op_t MD_DIVU   = 3'b101;
    localparam md_op_t MD_REM    = 3'b110;
    localparam md_op_t MD_REMU   = 3'b111;

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE  = 2'd0;
    localparam md_state_t ST_CALC  = 2'd1;
    localparam md_state_t ST_FIXUP = 2'd2;
    localparam md_state_t ST_DONE  = 2'd3;

    // MUL is treated as unsigned: the low half of the product does not depend on signedness.
    function automatic logic op_a_signed(input md_op_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_b_signed(input md_op_t op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring unsigned-division step: shifts the next dividend bit into the partial
// remainder and subtracts the divisor when it fits.
module divu_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    // The true difference is always below the divisor, so XLEN bits suffice for it.
    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted[XLEN-1:0] - divisor;
        fits    = (shifted >= {1'b0, divisor});
        rem_out = fits ? diff : shifted[XLEN-1:0];
        quo_out = {quo_in[XLEN-2:0], fits};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per
// cycle on magnitudes, sign fix-up at the end, valid/ready on both sides.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    md_state_t         state_reg;
    logic [CW-1:0]     cnt_reg;
    md_op_t            op_reg;
    logic              neg_reg;
    logic [XLEN-1:0]   b_mag_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   result_reg;

    logic              a_sign;
    logic              b_sign;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              b_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_val;
    logic              res_neg;

    always_comb begin
        a_sign  = op_a_signed(op) & A[XLEN-1];
        b_sign  = op_b_signed(op) & B[XLEN-1];
        a_mag   = a_sign ? -A : A;
        b_mag   = b_sign ? -B : B;
        b_zero  = (B == '0);
        div_ovf = ((op == MD_DIV) || (op == MD_REM)) &&
                  (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
        special = op[2] & (b_zero | div_ovf);
        if (b_zero) begin
            special_val = op[1] ? A : '1;
        end else begin
            special_val = op[1] ? '0 : A;
        end
        // Remainder follows the dividend; quotient and products follow the operand XOR.
        res_neg = (op[2] & op[1]) ? a_sign : (a_sign ^ b_sign);
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   div_rem_next;
    logic [XLEN-1:0]   div_quo_next;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, b_mag_reg};
        mul_next = acc_reg[0] ? {mul_sum, acc_reg[XLEN-1:1]}
                              : {1'b0, acc_reg[2*XLEN-1:1]};
    end

    divu_step #(
        .XLEN(XLEN)
    ) u_divu_step (
        .rem_in  (acc_reg[2*XLEN-1:XLEN]),
        .quo_in  (acc_reg[XLEN-1:0]),
        .divisor (b_mag_reg),
        .rem_out (div_rem_next),
        .quo_out (div_quo_next)
    );

    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   fixup_val;

    // Accumulator layout: multiply {hi, lo} product; divide {remainder, quotient}.
    always_comb begin
        prod_signed = neg_reg ? -acc_reg : acc_reg;
        div_sel     = op_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
        if (op_reg[2]) begin
            fixup_val = neg_reg ? -div_sel : div_sel;
        end else if (op_reg[1:0] == 2'b00) begin
            fixup_val = prod_signed[XLEN-1:0];
        end else begin
            fixup_val = prod_signed[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_reg     <= MD_MUL;
            neg_reg    <= 1'b0;
            b_mag_reg  <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else if (flush) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_reg <= op;
                        if (special) begin
                            result_reg <= special_val;
                            state_reg  <= ST_DONE;
                        end else begin
                            acc_reg   <= {{XLEN{1'b0}}, a_mag};
                            b_mag_reg <= b_mag;
                            neg_reg   <= res_neg;
                            cnt_reg   <= '0;
                            state_reg <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_reg <= op_reg[2] ? {div_rem_next, div_quo_next} : mul_next;
                    if (cnt_reg == CW'(XLEN-1)) begin
                        state_reg <= ST_FIXUP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_FIXUP: begin
                    result_reg <= fixup_val;
                    state_reg  <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE) & ~flush;
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign Result    = result_reg;

endmodule
